dp_mem_responder: RTL and testbench

Memory-side responder for the datapath's instruction/data request interface (imemREN/imemaddr/ihit, dmemREN/dmemWEN/dmemaddr/dmemstore/dhit, halt).
- Accepts one request at a time from the datapath.
- Arbitrates between I and D requests (D has priority).
- Issues the request to a single-ported RAM with variable latency (ramstate handshake).
- Returns data with a one-cycle hit pulse.
- Handles RAM errors with bounded retry and a watchdog timeout.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/req_watchdog.sv | 51 +++++
 rtl/dp_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_dp_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types.
//   word_t : one 32-bit machine word (addresses, instructions, data).
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mem_responder_pkg.sv
// Types for the datapath memory responder.
//   ramstate_t   : RAM handshake encoding presented on ramstate.
//   resp_state_t : responder FSM states, also exported on the debug port.
//   word_t       : machine word, re-exported from cpu_types_pkg.
package mem_responder_pkg;
    typedef cpu_types_pkg::word_t word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IREQ   = 3'd1,
        DREQ   = 3'd2,
        RESP   = 3'd3,
        HALTED = 3'd4,
        FAULT  = 3'd5
    } resp_state_t;
endpackage

// File: rtl/req_watchdog.sv
// Per-transaction attempt timer and retry counter.
//   CLK, nRST         : clock, asynchronous active-low reset
//   clear             : zero both counters (no transaction in flight / done)
//   tick              : an attempt is on the RAM bus this cycle
//   err               : RAM reported ERROR this cycle
//   expire            : attempt has been on the bus for TIMEOUT cycles
//   retries_exhausted : MAX_RETRY retries already used
module req_watchdog #(
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic tick,
    input  logic err,
    output logic expire,
    output logic retries_exhausted
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT  = '1;
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic          attempt_fail;

    assign expire            = tick && (timer >= T_LAST);
    assign retries_exhausted = (retry >= R_MAX);
    assign attempt_fail      = tick && (err || expire);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            timer <= '0;
            retry <= '0;
        end else if (clear) begin
            timer <= '0;
            retry <= '0;
        end else if (attempt_fail) begin
            // A failed attempt restarts the timer; the retry count never
            // passes MAX_RETRY, the FSM faults instead.
            timer <= '0;
            if (!retries_exhausted)
                retry <= retry + 1'b1;
        end else if (tick && (timer != T_SAT)) begin
            timer <= timer + 1'b1;
        end
    end
endmodule

// File: rtl/dp_mem_responder.sv
// Memory-side responder for the datapath I/D request interface.
// Takes one request at a time (D before I), runs it on a single-ported
// variable-latency RAM, and answers with a one-cycle ihit/dhit pulse.
//   CLK, nRST                         : clock, asynchronous active-low reset
//   imemREN, imemaddr                 : instruction fetch request
//   imemload, ihit                    : fetched word (registered), response pulse
//   dmemREN, dmemWEN, dmemaddr,
//   dmemstore                         : data read/write request
//   dmemload, dhit                    : load word (registered), response pulse
//   halt                              : datapath halted
//   ramREN, ramWEN, ramaddr, ramstore : RAM command
//   ramload, ramstate                 : RAM read data and handshake state
//   halted, fault                     : sticky terminal status
//   dbg_state                         : current FSM state
module dp_mem_responder
    import mem_responder_pkg::*;
#(
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        halt,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        halted,
    output logic        fault,
    output resp_state_t dbg_state
);
    // Handshake: the datapath holds a request level (imemREN, or
    // dmemREN/dmemWEN) with stable address/data until it sees the matching
    // hit pulse; a request is taken only in IDLE and is never preempted.
    // On the RAM side an issued command is held until ramstate == ACCESS
    // (done) or ERROR / watchdog expiry (attempt failed).

    resp_state_t state, next_state;

    word_t addr_q, store_q, imemload_q, dmemload_q;
    logic  write_q;    // latched D op is a write
    logic  src_d_q;    // current transaction came from the D port
    logic  gap_q;      // one idle cycle between a failed attempt and the reissue
    logic  dropped_q;  // requester withdrew before the response

    logic in_req, active, access, ram_err;
    logic latch_d, latch_i, set_gap;
    logic expire, retries_exhausted;

    assign in_req  = (state == IREQ) || (state == DREQ);
    assign active  = in_req && !gap_q;
    assign access  = active && (ramstate == ACCESS);
    assign ram_err = (ramstate == ERROR);

    req_watchdog #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_watchdog (
        .CLK               (CLK),
        .nRST              (nRST),
        .clear             (!in_req || access),
        .tick              (active),
        .err               (ram_err),
        .expire            (expire),
        .retries_exhausted (retries_exhausted)
    );

    always_comb begin
        next_state = state;
        latch_d    = 1'b0;
        latch_i    = 1'b0;
        set_gap    = 1'b0;
        case (state)
            IDLE: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (dmemREN || dmemWEN) begin
                    next_state = DREQ;
                    latch_d    = 1'b1;
                end else if (imemREN) begin
                    next_state = IREQ;
                    latch_i    = 1'b1;
                end
            end
            IREQ, DREQ: begin
                if (!gap_q) begin
                    // Completion wins over a coincident timer expiry.
                    if (ramstate == ACCESS) begin
                        next_state = RESP;
                    end else if (ram_err || expire) begin
                        if (retries_exhausted)
                            next_state = FAULT;
                        else
                            set_gap = 1'b1;
                    end
                end
            end
            RESP:    next_state = IDLE;
            HALTED:  next_state = HALTED;
            FAULT:   next_state = FAULT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            write_q    <= 1'b0;
            src_d_q    <= 1'b0;
            gap_q      <= 1'b0;
            dropped_q  <= 1'b0;
            imemload_q <= '0;
            dmemload_q <= '0;
        end else begin
            state <= next_state;
            gap_q <= set_gap;
            if (latch_d) begin
                addr_q    <= dmemaddr;
                store_q   <= dmemstore;
                write_q   <= dmemWEN;
                src_d_q   <= 1'b1;
                dropped_q <= 1'b0;
            end else if (latch_i) begin
                addr_q    <= imemaddr;
                store_q   <= '0;
                write_q   <= 1'b0;
                src_d_q   <= 1'b0;
                dropped_q <= 1'b0;
            end
            if ((state == IREQ && !imemREN) ||
                (state == DREQ && !(dmemREN || dmemWEN)))
                dropped_q <= 1'b1;
            // Data is captured even for a withdrawn request.
            if (access && !write_q) begin
                if (state == DREQ)
                    dmemload_q <= ramload;
                else
                    imemload_q <= ramload;
            end
        end
    end

    assign ramREN    = active && ((state == IREQ) || !write_q);
    assign ramWEN    = active && (state == DREQ) && write_q;
    assign ramaddr   = addr_q;
    assign ramstore  = store_q;
    assign ihit      = (state == RESP) && !src_d_q && !dropped_q;
    assign dhit      = (state == RESP) &&  src_d_q && !dropped_q;
    assign imemload  = imemload_q;
    assign dmemload  = dmemload_q;
    assign halted    = (state == HALTED);
    assign fault     = (state == FAULT);
    assign dbg_state = state;
endmodule

// File: tb/tb_dp_mem_responder.sv
module tb_dp_mem_responder;
  import mem_responder_pkg::*;

  logic        CLK, nRST;
  logic        imemREN, dmemREN, dmemWEN, halt;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, halted, fault;
  resp_state_t dbg_state;

  int checks;
  int errors;

  dp_mem_responder #(.TIMEOUT(8), .MAX_RETRY(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .halted(halted), .fault(fault), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    imemREN = 0; dmemREN = 0; dmemWEN = 0; halt = 0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0;
    ramstate = FREE;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({ramREN, ramWEN, ihit, dhit, halted, fault} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {ramREN, ramWEN, ihit, dhit, halted, fault});
    end
    checks++;
    if ({ramaddr, ramstore, imemload, dmemload} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected all 0", ramaddr, ramstore, imemload, dmemload);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_ifetch_busy();
    @(negedge CLK);
    imemREN = 1; imemaddr = 32'h40;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
        errors++;
        $display("FAIL ifetch_issue[%0d]: got ren=%b wen=%b addr=%h ihit=%b expected 1 0 00000040 0", c, ramREN, ramWEN, ramaddr, ihit);
      end
      ramstate = (c == 2) ? ACCESS : BUSY;
      ramload  = 32'h8C220004;
    end
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b1 || dhit !== 1'b0 || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_hit: got ihit=%b dhit=%b ren=%b expected 1 0 0", ihit, dhit, ramREN);
    end
    checks++;
    if (imemload !== 32'h8C220004) begin
      errors++;
      $display("FAIL ifetch_data: got %h expected 8c220004", imemload);
    end
    imemREN = 0; ramstate = FREE;
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL ifetch_done: got ihit=%b state=%0d expected 0 %0d", ihit, dbg_state, IDLE);
    end
  endtask

  task automatic test_dwrite_priority();
    @(negedge CLK);
    imemREN = 1; imemaddr = 32'h80;
    dmemWEN = 1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
    ramstate = ACCESS;
    @(negedge CLK);
    checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL prio_dwrite: got wen=%b ren=%b addr=%h store=%h expected 1 0 00000100 deadbeef", ramWEN, ramREN, ramaddr, ramstore);
    end
    @(negedge CLK);
    checks++;
    if (dhit !== 1'b1 || ihit !== 1'b0 || dmemload !== 32'h0) begin
      errors++;
      $display("FAIL prio_dhit: got dhit=%b ihit=%b dload=%h expected 1 0 00000000", dhit, ihit, dmemload);
    end
    dmemWEN = 0; ramload = 32'h11112222;
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b0 || dhit !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL prio_idle: got ihit=%b dhit=%b state=%0d expected 0 0 %0d", ihit, dhit, dbg_state, IDLE);
    end
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h80) begin
      errors++;
      $display("FAIL prio_ifetch: got ren=%b wen=%b addr=%h expected 1 0 00000080", ramREN, ramWEN, ramaddr);
    end
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b1 || dhit !== 1'b0 || imemload !== 32'h11112222) begin
      errors++;
      $display("FAIL prio_ihit: got ihit=%b dhit=%b iload=%h expected 1 0 11112222", ihit, dhit, imemload);
    end
    imemREN = 0; ramstate = FREE;
  endtask

  task automatic test_dread_retry();
    logic [1:0] rs_seq [5];
    logic       exp_ren [5];
    rs_seq  = '{ERROR, FREE, ERROR, FREE, ACCESS};
    exp_ren = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge CLK);
    dmemREN = 1; dmemaddr = 32'h200;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++;
      if (ramREN !== exp_ren[c] || ramWEN !== 1'b0 || ramaddr !== 32'h200 || dhit !== 1'b0) begin
        errors++;
        $display("FAIL retry_issue[%0d]: got ren=%b wen=%b addr=%h dhit=%b expected %b 0 00000200 0", c, ramREN, ramWEN, ramaddr, dhit, exp_ren[c]);
      end
      ramstate = rs_seq[c];
      ramload  = 32'h12345678;
    end
    @(negedge CLK);
    checks++;
    if (dhit !== 1'b1 || ihit !== 1'b0 || dmemload !== 32'h12345678 || fault !== 1'b0) begin
      errors++;
      $display("FAIL retry_hit: got dhit=%b ihit=%b dload=%h fault=%b expected 1 0 12345678 0", dhit, ihit, dmemload, fault);
    end
    dmemREN = 0; ramstate = FREE;
  endtask

  task automatic test_d_read_write_both();
    @(negedge CLK);
    dmemREN = 1; dmemWEN = 1; dmemaddr = 32'h140; dmemstore = 32'h0BADF00D;
    ramstate = ACCESS; ramload = 32'hFFFF0000;
    @(negedge CLK);
    checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL both_as_write: got wen=%b ren=%b store=%h expected 1 0 0badf00d", ramWEN, ramREN, ramstore);
    end
    @(negedge CLK);
    checks++;
    if (dhit !== 1'b1 || dmemload !== 32'h12345678) begin
      errors++;
      $display("FAIL both_hit: got dhit=%b dload=%h expected 1 12345678", dhit, dmemload);
    end
    dmemREN = 0; dmemWEN = 0; ramstate = FREE;
  endtask

  task automatic test_dropped_request();
    @(negedge CLK);
    imemREN = 1; imemaddr = 32'h500;
    @(negedge CLK);
    imemREN = 0; ramstate = BUSY;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
      errors++;
      $display("FAIL drop_hold: got ren=%b addr=%h expected 1 00000500", ramREN, ramaddr);
    end
    ramstate = ACCESS; ramload = 32'hA5A5A5A5;
    @(negedge CLK);
    checks++;
    if (ihit !== 1'b0 || dhit !== 1'b0 || imemload !== 32'hA5A5A5A5 || dbg_state !== RESP) begin
      errors++;
      $display("FAIL drop_resp: got ihit=%b dhit=%b iload=%h state=%0d expected 0 0 a5a5a5a5 %0d", ihit, dhit, imemload, dbg_state, RESP);
    end
    ramstate = FREE;
  endtask

  task automatic test_halt();
    @(negedge CLK);
    halt = 1; imemREN = 1; imemaddr = 32'h600;
    @(negedge CLK);
    checks++;
    if (halted !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: got halted=%b ren=%b wen=%b expected 1 0 0", halted, ramREN, ramWEN);
    end
    halt = 0; ramstate = ACCESS;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      checks++;
      if (halted !== 1'b1 || ramREN !== 1'b0 || ihit !== 1'b0 || fault !== 1'b0) begin
        errors++;
        $display("FAIL halt_sticky[%0d]: got halted=%b ren=%b ihit=%b fault=%b expected 1 0 0 0", c, halted, ramREN, ihit, fault);
      end
    end
    apply_reset();
  endtask

  task automatic test_timeout_fault();
    logic exp_ren, exp_fault;
    int   ren_cycles;
    int   ihit_seen;
    ren_cycles = 0; ihit_seen = 0;
    @(negedge CLK);
    imemREN = 1; imemaddr = 32'h300; ramstate = BUSY;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      // attempts of 8 cycles separated by one idle cycle, then FAULT at 36
      exp_ren   = (c <= 35) && ((c % 9) != 0);
      exp_fault = (c >= 36);
      if (ramREN) ren_cycles++;
      if (ihit) ihit_seen++;
      checks++;
      if (ramREN !== exp_ren || fault !== exp_fault || ramWEN !== 1'b0) begin
        errors++;
        $display("FAIL timeout_cycle[%0d]: got ren=%b fault=%b wen=%b expected %b %b 0", c, ramREN, fault, ramWEN, exp_ren, exp_fault);
      end
    end
    checks++;
    if (ren_cycles != 32 || ihit_seen != 0) begin
      errors++;
      $display("FAIL timeout_totals: got ren_cycles=%0d ihits=%0d expected 32 0", ren_cycles, ihit_seen);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_txn();
    @(negedge CLK);
    dmemWEN = 1; dmemaddr = 32'h400; dmemstore = 32'hCAFEF00D; ramstate = BUSY;
    @(negedge CLK);
    checks++;
    if (ramWEN !== 1'b1 || ramaddr !== 32'h400) begin
      errors++;
      $display("FAIL rst_mid_before: got wen=%b addr=%h expected 1 00000400", ramWEN, ramaddr);
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got wen=%b ren=%b expected 0 0", ramWEN, ramREN);
    end
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN, ihit, dhit, halted, fault} !== 6'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL rst_mid_after: got ctrl=%b state=%0d expected 000000 %0d", {ramREN, ramWEN, ihit, dhit, halted, fault}, dbg_state, IDLE);
    end
    checks++;
    if ({ramaddr, ramstore, imemload, dmemload} !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid_data: got %h %h %h %h expected all 0", ramaddr, ramstore, imemload, dmemload);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    apply_reset();
    test_reset();
    test_ifetch_busy();
    test_dwrite_priority();
    test_dread_retry();
    test_d_read_write_both();
    test_dropped_request();
    test_halt();
    test_timeout_fault();
    test_reset_mid_txn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
